pl_controller: RTL and testbench

//  Pipelined control unit for the 5-stage RV32I core; successor of the single-cycle controller.

---
 rtl/pl_controller.sv | 203 ++++++++++++++++++++
 tb/tb_pl_controller.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pl_controller.sv
// pl_controller: pipelined RV32I control unit with Decode, ID/EX, EX/MEM and MEM/WB control registers
module pl_controller #(
    parameter int ALU_CTRL_W   = 4,
    parameter bit BRANCH_FULL  = 1'b1,
    parameter bit ENABLE_UTYPE = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            opD,
    input  logic [2:0]            funct3D,
    input  logic                  funct7b5D,
    input  logic                  StallE,
    input  logic                  FlushE,
    input  logic                  ZeroE,
    input  logic                  LtE,
    input  logic                  LtuE,
    output logic [2:0]            ImmSrcD,
    output logic                  IllegalD,
    output logic [ALU_CTRL_W-1:0] ALUControlE,
    output logic                  ALUSrcAE,
    output logic                  ALUSrcBE,
    output logic                  PCSrcE,
    output logic                  JalrE,
    output logic                  ResultSrcE0,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic [2:0]            Funct3M,
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW
);
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic                  reg_write;
        logic [1:0]            result_src;
        logic                  mem_write;
        logic                  jump;
        logic                  branch;
        logic                  jalr;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        logic                  alu_src_a;
        logic                  alu_src_b;
        logic [2:0]            funct3;
    } ctrl_t;

    ctrl_t      ctrl_d;
    ctrl_t      id_ex_q;
    logic [3:0] alu_f3;
    logic [3:0] alu_op;
    logic [2:0] imm_src;
    logic       illegal;
    logic       br_cond;
    logic       ex_mem_rw_q;
    logic [1:0] ex_mem_rs_q;
    logic       ex_mem_mw_q;
    logic [2:0] ex_mem_f3_q;
    logic       mem_wb_rw_q;
    logic [1:0] mem_wb_rs_q;

    // ALU operation selected by funct3 for R-type and I-ALU; only R-type uses funct7b5 on 000
    always_comb begin
        case (funct3D)
            3'b000:  alu_f3 = (opD == OP_R && funct7b5D) ? 4'd1 : 4'd0;
            3'b001:  alu_f3 = 4'd7;
            3'b010:  alu_f3 = 4'd5;
            3'b011:  alu_f3 = 4'd6;
            3'b100:  alu_f3 = 4'd4;
            3'b101:  alu_f3 = funct7b5D ? 4'd9 : 4'd8;
            3'b110:  alu_f3 = 4'd3;
            default: alu_f3 = 4'd2;
        endcase
    end

    // Main decoder; unsupported opcodes yield an all-zero bubble bundle
    always_comb begin
        ctrl_d  = '0;
        alu_op  = 4'd0;
        imm_src = 3'b000;
        illegal = 1'b0;
        case (opD)
            OP_LW: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = 2'b01;
                ctrl_d.alu_src_b  = 1'b1;
            end
            OP_SW: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src_b = 1'b1;
                imm_src          = 3'b001;
            end
            OP_R: begin
                ctrl_d.reg_write = 1'b1;
                alu_op           = alu_f3;
            end
            OP_I: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src_b = 1'b1;
                alu_op           = alu_f3;
            end
            OP_B: begin
                ctrl_d.branch = 1'b1;
                alu_op        = 4'd1;
                imm_src       = 3'b010;
            end
            OP_JAL: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = 2'b10;
                ctrl_d.jump       = 1'b1;
                imm_src           = 3'b011;
            end
            OP_JALR: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = 2'b10;
                ctrl_d.jump       = 1'b1;
                ctrl_d.jalr       = 1'b1;
                ctrl_d.alu_src_b  = 1'b1;
            end
            OP_LUI: begin
                if (ENABLE_UTYPE) begin
                    ctrl_d.reg_write  = 1'b1;
                    ctrl_d.result_src = 2'b11;
                    imm_src           = 3'b100;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_AUIPC: begin
                if (ENABLE_UTYPE) begin
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.alu_src_a = 1'b1;
                    ctrl_d.alu_src_b = 1'b1;
                    imm_src          = 3'b100;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        ctrl_d.alu_ctrl = ALU_CTRL_W'(alu_op);
        ctrl_d.funct3   = illegal ? 3'b000 : funct3D;
    end

    // ID/EX register: flush beats stall, stall holds the current bundle
    always_ff @(posedge clk) begin
        if (reset || FlushE) id_ex_q <= '0;
        else if (!StallE) id_ex_q <= ctrl_d;
    end

    // EX/MEM and MEM/WB advance unconditionally; only reset clears them
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_mem_rw_q <= 1'b0;
            ex_mem_rs_q <= 2'b00;
            ex_mem_mw_q <= 1'b0;
            ex_mem_f3_q <= 3'b000;
            mem_wb_rw_q <= 1'b0;
            mem_wb_rs_q <= 2'b00;
        end else begin
            ex_mem_rw_q <= id_ex_q.reg_write;
            ex_mem_rs_q <= id_ex_q.result_src;
            ex_mem_mw_q <= id_ex_q.mem_write;
            ex_mem_f3_q <= id_ex_q.funct3;
            mem_wb_rw_q <= ex_mem_rw_q;
            mem_wb_rs_q <= ex_mem_rs_q;
        end
    end

    // Branch condition from comparator flags; funct3[0] inverts, 010/011 never taken
    always_comb begin
        case (id_ex_q.funct3)
            3'b000:  br_cond = ZeroE;
            3'b001:  br_cond = !ZeroE;
            3'b100:  br_cond = LtE;
            3'b101:  br_cond = !LtE;
            3'b110:  br_cond = LtuE;
            3'b111:  br_cond = !LtuE;
            default: br_cond = 1'b0;
        endcase
        if (!BRANCH_FULL && id_ex_q.funct3[2]) br_cond = 1'b0;
    end

    assign ImmSrcD     = imm_src;
    assign IllegalD    = illegal;
    assign ALUControlE = id_ex_q.alu_ctrl;
    assign ALUSrcAE    = id_ex_q.alu_src_a;
    assign ALUSrcBE    = id_ex_q.alu_src_b;
    assign PCSrcE      = id_ex_q.jump | (id_ex_q.branch & br_cond);
    assign JalrE       = id_ex_q.jalr;
    assign ResultSrcE0 = id_ex_q.result_src[0];
    assign RegWriteM   = ex_mem_rw_q;
    assign MemWriteM   = ex_mem_mw_q;
    assign Funct3M     = ex_mem_f3_q;
    assign RegWriteW   = mem_wb_rw_q;
    assign ResultSrcW  = mem_wb_rs_q;
endmodule

// File: tb/tb_pl_controller.sv
// tb_pl_controller: directed and randomized checks of pl_controller against a decode-table reference model
module tb_pl_controller;
    localparam logic [6:0] LW    = 7'b0000011;
    localparam logic [6:0] SW    = 7'b0100011;
    localparam logic [6:0] RT    = 7'b0110011;
    localparam logic [6:0] IT    = 7'b0010011;
    localparam logic [6:0] BR    = 7'b1100011;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;

    typedef struct packed {
        logic       ill;
        logic       rw;
        logic [1:0] rs;
        logic       mw;
        logic       jmp;
        logic       br;
        logic       jalr;
        logic [3:0] alu;
        logic       sa;
        logic       sb;
        logic [2:0] f3;
        logic [2:0] imm;
    } b_t;

    logic       clk = 1'b0;
    logic       reset, funct7b5D, StallE, FlushE, ZeroE, LtE, LtuE;
    logic [6:0] opD;
    logic [2:0] funct3D;
    int         checks = 0;
    int         failures = 0;

    logic [2:0] imm_a, imm_b, imm_c, f3m_a, f3m_b, f3m_c;
    logic [3:0] alu_a, alu_b, alu_c;
    logic [1:0] rsw_a, rsw_b, rsw_c;
    logic ill_a, sa_a, sb_a, pc_a, jalr_a, rse0_a, rwm_a, mwm_a, rww_a;
    logic ill_b, sa_b, sb_b, pc_b, jalr_b, rse0_b, rwm_b, mwm_b, rww_b;
    logic ill_c, sa_c, sb_c, pc_c, jalr_c, rse0_c, rwm_c, mwm_c, rww_c;

    always #5 clk = ~clk;

    pl_controller dut (
        .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
        .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
        .ImmSrcD(imm_a), .IllegalD(ill_a), .ALUControlE(alu_a), .ALUSrcAE(sa_a), .ALUSrcBE(sb_a),
        .PCSrcE(pc_a), .JalrE(jalr_a), .ResultSrcE0(rse0_a), .RegWriteM(rwm_a), .MemWriteM(mwm_a),
        .Funct3M(f3m_a), .RegWriteW(rww_a), .ResultSrcW(rsw_a)
    );

    pl_controller #(.BRANCH_FULL(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
        .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
        .ImmSrcD(imm_b), .IllegalD(ill_b), .ALUControlE(alu_b), .ALUSrcAE(sa_b), .ALUSrcBE(sb_b),
        .PCSrcE(pc_b), .JalrE(jalr_b), .ResultSrcE0(rse0_b), .RegWriteM(rwm_b), .MemWriteM(mwm_b),
        .Funct3M(f3m_b), .RegWriteW(rww_b), .ResultSrcW(rsw_b)
    );

    pl_controller #(.ENABLE_UTYPE(1'b0)) dut_nu (
        .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
        .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
        .ImmSrcD(imm_c), .IllegalD(ill_c), .ALUControlE(alu_c), .ALUSrcAE(sa_c), .ALUSrcBE(sb_c),
        .PCSrcE(pc_c), .JalrE(jalr_c), .ResultSrcE0(rse0_c), .RegWriteM(rwm_c), .MemWriteM(mwm_c),
        .Funct3M(f3m_c), .RegWriteW(rww_c), .ResultSrcW(rsw_c)
    );

    // Reference decode: one row per instruction class; ALU code looked up from a funct3 table
    function automatic b_t dec(input logic [6:0] op, input logic [2:0] f3, input logic f7, input bit ut);
        b_t          b;
        logic [31:0] tab;
        b   = '0;
        tab = 32'h2384_6570;
        b.f3 = f3;
        if (op == RT || op == IT) begin
            b.rw  = 1'b1;
            b.sb  = (op == IT);
            b.alu = tab[{f3, 2'b00} +: 4] + 4'(((f3 == 3'd0) && f7 && op == RT) || ((f3 == 3'd5) && f7));
        end else if (op == LW) begin
            b.rw = 1'b1; b.rs = 2'b01; b.sb = 1'b1;
        end else if (op == SW) begin
            b.mw = 1'b1; b.sb = 1'b1; b.imm = 3'b001;
        end else if (op == BR) begin
            b.br = 1'b1; b.alu = 4'd1; b.imm = 3'b010;
        end else if (op == JAL) begin
            b.rw = 1'b1; b.rs = 2'b10; b.jmp = 1'b1; b.imm = 3'b011;
        end else if (op == JALR) begin
            b.rw = 1'b1; b.rs = 2'b10; b.jmp = 1'b1; b.jalr = 1'b1; b.sb = 1'b1;
        end else if (ut && op == LUI) begin
            b.rw = 1'b1; b.rs = 2'b11; b.imm = 3'b100;
        end else if (ut && op == AUIPC) begin
            b.rw = 1'b1; b.sa = 1'b1; b.sb = 1'b1; b.imm = 3'b100;
        end else begin
            b = '0;
            b.ill = 1'b1;
        end
        return b;
    endfunction

    // Reference branch outcome: pick the flag by funct3[2:1], invert with funct3[0]
    function automatic logic taken(input logic [2:0] f3, input bit full, input logic z, input logic lt, input logic ltu);
        if (f3[2:1] == 2'b00) return z ^ f3[0];
        if (!full || f3[2:1] == 2'b01) return 1'b0;
        return (f3[1] ? ltu : lt) ^ f3[0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opD = op;
        funct3D = f3;
        funct7b5D = f7;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drive(JAL, 3'b000, 1'b0);
        repeat (3) tick();
        reset = 1'b1;
        ZeroE = 1'b1; LtE = 1'b1; LtuE = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(7'($urandom), 3'($urandom), 1'($urandom));
            tick();
            checks++;
            if ({alu_a, sa_a, sb_a, jalr_a, rse0_a, rwm_a, mwm_a, f3m_a, rww_a, rsw_a} !== 18'd0) begin
                failures++;
                $display("FAIL reset_regs cycle %0d: got %h want 0", i,
                         {alu_a, sa_a, sb_a, jalr_a, rse0_a, rwm_a, mwm_a, f3m_a, rww_a, rsw_a});
            end
            checks++;
            if (pc_a !== 1'b0 || pc_b !== 1'b0) begin
                failures++;
                $display("FAIL reset_pcsrc cycle %0d: got %b/%b want 0", i, pc_a, pc_b);
            end
        end
        reset = 1'b0;
        ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
    endtask

    task automatic test_stream;
        drive(RT, 3'b000, 1'b0);
        tick();
        checks++;
        if (alu_a !== 4'd0 || sb_a !== 1'b0) begin
            failures++;
            $display("FAIL stream_add_E: alu=%0d srcb=%b want 0/0", alu_a, sb_a);
        end
        drive(SW, 3'b010, 1'b0);
        tick();
        drive(LW, 3'b010, 1'b0);
        tick();
        checks++;
        if (rww_a !== 1'b1 || rsw_a !== 2'b00) begin
            failures++;
            $display("FAIL stream_add_W: regwrite=%b resultsrc=%b want 1/00", rww_a, rsw_a);
        end
        checks++;
        if (mwm_a !== 1'b1 || f3m_a !== 3'b010) begin
            failures++;
            $display("FAIL stream_sw_M: memwrite=%b funct3=%b want 1/010", mwm_a, f3m_a);
        end
        checks++;
        if (rse0_a !== 1'b1) begin
            failures++;
            $display("FAIL stream_lw_E: resultsrc0=%b want 1", rse0_a);
        end
        drive(IT, 3'b000, 1'b0);
        tick();
        checks++;
        if (mwm_a !== 1'b0 || rwm_a !== 1'b1 || rww_a !== 1'b0) begin
            failures++;
            $display("FAIL stream_lw_M: memwrite=%b regwriteM=%b regwriteW=%b want 0/1/0", mwm_a, rwm_a, rww_a);
        end
        tick();
        checks++;
        if (rww_a !== 1'b1 || rsw_a !== 2'b01) begin
            failures++;
            $display("FAIL stream_lw_W: regwrite=%b resultsrc=%b want 1/01", rww_a, rsw_a);
        end
    endtask

    task automatic test_alu_decode;
        drive(RT, 3'b000, 1'b1);
        tick();
        checks++;
        if (alu_a !== 4'd1) begin failures++; $display("FAIL alu_sub: got %0d want 1", alu_a); end
        drive(IT, 3'b000, 1'b1);
        tick();
        checks++;
        if (alu_a !== 4'd0) begin failures++; $display("FAIL alu_addi_f7: got %0d want 0", alu_a); end
        drive(IT, 3'b101, 1'b1);
        tick();
        checks++;
        if (alu_a !== 4'd9) begin failures++; $display("FAIL alu_srai: got %0d want 9", alu_a); end
        drive(RT, 3'b101, 1'b0);
        tick();
        checks++;
        if (alu_a !== 4'd8) begin failures++; $display("FAIL alu_srl: got %0d want 8", alu_a); end
        drive(SW, 3'b000, 1'b0);
        #1;
        checks++;
        if (imm_a !== 3'b001 || ill_a !== 1'b0) begin
            failures++;
            $display("FAIL immsrc_sw: got %b/%b want 001/0", imm_a, ill_a);
        end
    endtask

    task automatic test_branch;
        ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
        drive(BR, 3'b100, 1'b0);
        tick();
        drive(IT, 3'b000, 1'b0);
        LtE = 1'b1;
        #1;
        checks++;
        if (pc_a !== 1'b1 || pc_b !== 1'b0) begin
            failures++;
            $display("FAIL blt_taken: full=%b nofull=%b want 1/0", pc_a, pc_b);
        end
        LtE = 1'b0;
        #1;
        checks++;
        if (pc_a !== 1'b0 || pc_b !== 1'b0) begin
            failures++;
            $display("FAIL blt_not_taken: full=%b nofull=%b want 0/0", pc_a, pc_b);
        end
        drive(BR, 3'b001, 1'b0);
        tick();
        drive(IT, 3'b000, 1'b0);
        ZeroE = 1'b0;
        #1;
        checks++;
        if (pc_a !== 1'b1 || pc_b !== 1'b1) begin
            failures++;
            $display("FAIL bne_taken: full=%b nofull=%b want 1/1", pc_a, pc_b);
        end
        drive(JALR, 3'b000, 1'b0);
        tick();
        drive(IT, 3'b000, 1'b0);
        #1;
        checks++;
        if (pc_a !== 1'b1 || jalr_a !== 1'b1 || sb_a !== 1'b1) begin
            failures++;
            $display("FAIL jalr_E: pcsrc=%b jalr=%b srcb=%b want 1/1/1", pc_a, jalr_a, sb_a);
        end
    endtask

    task automatic test_stall_flush;
        ZeroE = 1'b1; LtE = 1'b1; LtuE = 1'b1;
        drive(LW, 3'b010, 1'b0);
        tick();
        drive(RT, 3'b000, 1'b0);
        StallE = 1'b1;
        tick();
        StallE = 1'b0;
        checks++;
        if (rse0_a !== 1'b1 || sb_a !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold: resultsrc0=%b srcb=%b want 1/1", rse0_a, sb_a);
        end
        tick();
        checks++;
        if (rse0_a !== 1'b0 || sb_a !== 1'b0) begin
            failures++;
            $display("FAIL stall_release: resultsrc0=%b srcb=%b want 0/0", rse0_a, sb_a);
        end
        drive(RT, 3'b000, 1'b1);
        tick();
        StallE = 1'b1;
        FlushE = 1'b1;
        tick();
        StallE = 1'b0;
        FlushE = 1'b0;
        checks++;
        if (alu_a !== 4'd0 || pc_a !== 1'b0 || rse0_a !== 1'b0) begin
            failures++;
            $display("FAIL flush_over_stall: alu=%0d pcsrc=%b want 0/0", alu_a, pc_a);
        end
        drive(RT, 3'b000, 1'b0);
        tick();
        checks++;
        if (rwm_a !== 1'b0) begin failures++; $display("FAIL flush_bubble_M: regwrite=%b want 0", rwm_a); end
    endtask

    task automatic test_illegal;
        ZeroE = 1'b1;
        drive(RT, 3'b000, 1'b0);
        tick();
        drive(SW, 3'b010, 1'b0);
        tick();
        drive(7'b1111111, 3'b101, 1'b1);
        #1;
        checks++;
        if (ill_a !== 1'b1 || imm_a !== 3'b000) begin
            failures++;
            $display("FAIL illegal_D: illegal=%b immsrc=%b want 1/000", ill_a, imm_a);
        end
        tick();
        checks++;
        if ({alu_a, sa_a, sb_a, pc_a, jalr_a, rse0_a} !== 9'd0 || mwm_a !== 1'b1) begin
            failures++;
            $display("FAIL illegal_E: bundle=%h memwriteM=%b want 0/1",
                     {alu_a, sa_a, sb_a, pc_a, jalr_a, rse0_a}, mwm_a);
        end
        drive(RT, 3'b000, 1'b0);
        tick();
        checks++;
        if (mwm_a !== 1'b0 || rwm_a !== 1'b0 || f3m_a !== 3'b000) begin
            failures++;
            $display("FAIL illegal_M: memwrite=%b regwrite=%b funct3=%b want 0/0/000", mwm_a, rwm_a, f3m_a);
        end
        tick();
        checks++;
        if (rww_a !== 1'b0) begin failures++; $display("FAIL illegal_W: regwrite=%b want 0", rww_a); end
    endtask

    task automatic test_utype;
        drive(LUI, 3'b000, 1'b0);
        #1;
        checks++;
        if (ill_c !== 1'b1 || ill_a !== 1'b0 || imm_a !== 3'b100) begin
            failures++;
            $display("FAIL lui_decode: illegal_nu=%b illegal=%b immsrc=%b want 1/0/100", ill_c, ill_a, imm_a);
        end
        drive(AUIPC, 3'b000, 1'b0);
        #1;
        checks++;
        if (ill_c !== 1'b1 || ill_a !== 1'b0) begin
            failures++;
            $display("FAIL auipc_decode: illegal_nu=%b illegal=%b want 1/0", ill_c, ill_a);
        end
        drive(LUI, 3'b000, 1'b0);
        repeat (3) tick();
        checks++;
        if (rww_a !== 1'b1 || rsw_a !== 2'b11 || rww_c !== 1'b0) begin
            failures++;
            $display("FAIL lui_W: regwrite=%b resultsrc=%b regwrite_nu=%b want 1/11/0", rww_a, rsw_a, rww_c);
        end
    endtask

    task automatic test_random;
        b_t         e, m, w, d, du;
        int         k;
        logic [6:0] ops [10] = '{LW, SW, RT, IT, BR, JAL, JALR, LUI, AUIPC, 7'b1111111};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        e = '0; m = '0; w = '0;
        for (int n = 0; n < 600; n++) begin
            k = $urandom_range(0, 10);
            opD = (k == 10) ? 7'($urandom) : ops[k];
            funct3D = 3'($urandom);
            funct7b5D = 1'($urandom);
            StallE = ($urandom_range(0, 5) == 0);
            FlushE = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 40) == 0);
            ZeroE = 1'($urandom); LtE = 1'($urandom); LtuE = 1'($urandom);
            #1;
            d  = dec(opD, funct3D, funct7b5D, 1'b1);
            du = dec(opD, funct3D, funct7b5D, 1'b0);
            checks++;
            if (imm_a !== d.imm || ill_a !== d.ill || ill_c !== du.ill) begin
                failures++;
                $display("FAIL rnd_decode n=%0d op=%b: imm=%b ill=%b ill_nu=%b want %b/%b/%b",
                         n, opD, imm_a, ill_a, ill_c, d.imm, d.ill, du.ill);
            end
            checks++;
            if ({alu_a, sa_a, sb_a, jalr_a, rse0_a} !== {e.alu, e.sa, e.sb, e.jalr, e.rs[0]}) begin
                failures++;
                $display("FAIL rnd_E n=%0d: got %h want %h", n, {alu_a, sa_a, sb_a, jalr_a, rse0_a},
                         {e.alu, e.sa, e.sb, e.jalr, e.rs[0]});
            end
            checks++;
            if (pc_a !== (e.jmp | (e.br & taken(e.f3, 1'b1, ZeroE, LtE, LtuE))) ||
                pc_b !== (e.jmp | (e.br & taken(e.f3, 1'b0, ZeroE, LtE, LtuE)))) begin
                failures++;
                $display("FAIL rnd_pcsrc n=%0d f3=%b: got %b/%b", n, e.f3, pc_a, pc_b);
            end
            checks++;
            if ({rwm_a, mwm_a, f3m_a} !== {m.rw, m.mw, m.f3}) begin
                failures++;
                $display("FAIL rnd_M n=%0d: got %b want %b", n, {rwm_a, mwm_a, f3m_a}, {m.rw, m.mw, m.f3});
            end
            checks++;
            if ({rww_a, rsw_a} !== {w.rw, w.rs}) begin
                failures++;
                $display("FAIL rnd_W n=%0d: got %b want %b", n, {rww_a, rsw_a}, {w.rw, w.rs});
            end
            @(posedge clk);
            if (reset) begin
                e = '0; m = '0; w = '0;
            end else begin
                w = m;
                m = e;
                e = FlushE ? b_t'(0) : (StallE ? e : d);
            end
            #1;
        end
        reset = 1'b0;
        StallE = 1'b0;
        FlushE = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        StallE = 1'b0; FlushE = 1'b0;
        ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
        drive(IT, 3'b000, 1'b0);
        test_reset();
        test_stream();
        test_alu_decode();
        test_branch();
        test_stall_flush();
        test_illegal();
        test_utype();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
